// File: rtl/dzmux_pkg.sv
// Shared definitions for the DZ-style terminal multiplexer: register map,
// CSR/RBUF bit positions and the receive silo entry layout.
package dzmux_pkg;

    localparam logic [1:0] ADDR_CSR  = 2'd0;
    localparam logic [1:0] ADDR_RBUF = 2'd1;
    localparam logic [1:0] ADDR_TCR  = 2'd2;
    localparam logic [1:0] ADDR_TDR  = 2'd3;

    localparam int CSR_TIE   = 14;
    localparam int CSR_SAE   = 12;
    localparam int CSR_RIE   = 6;
    localparam int CSR_MSE   = 5;
    localparam int CSR_CLR   = 4;
    localparam int CSR_MAI   = 3;

    localparam int LPR_RXON  = 12;

    // Line field is sized for the largest supported mux (16 lines).
    typedef struct packed {
        logic       ovr;
        logic [3:0] line;
        logic [7:0] ch;
    } silo_entry_t;

    typedef enum logic {
        PR_IDLE,
        PR_BUSY
    } pr_state_t;

endpackage

// File: rtl/dzmux_silo.sv
// Receive silo: circular FIFO of {line, char} with fill count, alarm level
// and overrun tagging of the newest stored entry when a push finds it full.
module dzmux_silo
    import dzmux_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int ALARM = 16
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        clear,
    input  logic        push,
    input  logic [3:0]  push_line,
    input  logic [7:0]  push_char,
    input  logic        pop,
    output silo_entry_t head,
    output logic        not_empty,
    output logic        alarm
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    silo_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          do_push;
    logic          do_pop;
    logic          do_ovr;

    assign full      = (count == CW'(DEPTH));
    assign not_empty = (count != '0);
    assign alarm     = (count >= CW'(ALARM));
    assign head      = mem[rd_ptr];
    assign do_pop    = pop & not_empty;
    // A pop in the same cycle frees the slot, so a push on full still lands.
    assign do_push   = push & (~full | do_pop);
    assign do_ovr    = push & full & ~do_pop;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (do_push) mem[wr_ptr] <= '{ovr: 1'b0, line: push_line, ch: push_char};
        if (do_ovr)  mem[wr_ptr - AW'(1)].ovr <= 1'b1;
    end

endmodule

// File: rtl/dzmux.sv
// Terminal multiplexer: bus register file, keyboard receive silo, transmit
// scanner, round-robin printer arbiter with maintenance loopback, and CLR.
module dzmux
    import dzmux_pkg::*;
#(
    parameter int NLINES    = 8,
    parameter int SILODEPTH = 64,
    parameter int ALARMLVL  = 16,
    parameter int CLRCYCLES = 1500,
    localparam int LW       = $clog2(NLINES)
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          init,
    input  logic          bus_wr,
    input  logic          bus_rd,
    input  logic [1:0]    bus_addr,
    input  logic [1:0]    bus_be,
    input  logic [15:0]   bus_wdata,
    output logic [15:0]   bus_rdata,
    input  logic          kb_valid,
    input  logic [LW-1:0] kb_line,
    input  logic [7:0]    kb_char,
    output logic          kb_ready,
    output logic          pr_valid,
    output logic [LW-1:0] pr_line,
    output logic [7:0]    pr_char,
    input  logic          pr_ack,
    output logic          rx_irq,
    output logic          tx_irq
);

    localparam int CCW = $clog2(CLRCYCLES + 1);

    logic              tie, sae, rie, mse, mai;
    logic [CCW-1:0]    clr_cnt;
    logic [NLINES-1:0] rxenab, txenab, prful;
    logic [NLINES-1:0] set_mask, ack_mask;
    logic [7:0]        prbuf [NLINES];
    logic [LW-1:0]     tline, rr_ptr, idx, pick_line;
    logic              pick_found;
    logic              lb_pend;
    logic [LW-1:0]     lb_line;
    logic [7:0]        lb_char;
    pr_state_t         pr_state;
    silo_entry_t       head;
    logic              rdone, sa, trdy;
    logic              clr_act, clr_start, wipe, wr_ok;
    logic              wr_csr, wr_lpr, wr_tcr, wr_tdr;
    logic              kb_push, lb_push, pr_load, pr_done;
    logic [15:0]       csr_val, rbuf_val;
    logic              unused_wdata;

    assign clr_act   = (clr_cnt != '0);
    assign wr_ok     = bus_wr & ~clr_act;
    assign wr_csr    = wr_ok & (bus_addr == ADDR_CSR);
    assign wr_lpr    = wr_ok & (bus_addr == ADDR_RBUF) & bus_be[0];
    assign wr_tcr    = wr_ok & (bus_addr == ADDR_TCR);
    assign wr_tdr    = wr_ok & (bus_addr == ADDR_TDR) & bus_be[0];
    assign clr_start = wr_csr & bus_be[0] & bus_wdata[CSR_CLR];
    assign wipe      = init | clr_act | clr_start;

    assign trdy      = txenab[tline] & ~prful[tline];
    assign kb_ready  = mse & ~clr_act;
    assign kb_push   = kb_valid & kb_ready & rxenab[kb_line];
    // Keyboard wins the silo port; a pending loopback char waits a cycle.
    assign lb_push   = lb_pend & ~kb_push;
    assign pr_load   = (pr_state == PR_IDLE) & pick_found & ~lb_pend & ~wipe;
    assign pr_done   = (pr_state == PR_BUSY) & pr_ack;

    assign rx_irq    = rie & (sae ? sa : rdone);
    assign tx_irq    = tie & trdy;

    assign csr_val   = {trdy, tie, sa, sae, 4'(tline), rdone, rie, mse, clr_act, mai, 3'b000};
    assign rbuf_val  = rdone ? {1'b1, head.ovr, 2'b00, head.line, head.ch} : 16'h0000;
    assign unused_wdata = ^{bus_wdata[15], bus_wdata[13], bus_wdata[11:8]};

    dzmux_silo #(.DEPTH(SILODEPTH), .ALARM(ALARMLVL)) u_silo (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .clear     (wipe),
        .push      ((kb_push | lb_push) & ~wipe),
        .push_line (kb_push ? 4'(kb_line) : 4'(lb_line)),
        .push_char (kb_push ? kb_char : lb_char),
        .pop       (bus_rd & (bus_addr == ADDR_RBUF) & ~wipe),
        .head      (head),
        .not_empty (rdone),
        .alarm     (sa)
    );

    // Round-robin search: lowest offset from rr_ptr with a full buffer wins.
    always_comb begin
        pick_found = 1'b0;
        pick_line  = rr_ptr;
        idx        = '0;
        for (int i = NLINES - 1; i >= 0; i--) begin
            idx = rr_ptr + LW'(i);
            if (prful[idx]) begin
                pick_found = 1'b1;
                pick_line  = idx;
            end
        end
    end

    always_comb begin
        set_mask = '0;
        ack_mask = '0;
        if (wr_tdr)  set_mask[tline]   = 1'b1;
        if (pr_done) ack_mask[pr_line] = 1'b1;
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            {tie, sae, rie, mse, mai} <= '0;
            clr_cnt <= '0;
            rxenab  <= '0;
            txenab  <= '0;
            prful   <= '0;
            tline   <= '0;
        end else begin
            if (init)           clr_cnt <= '0;
            else if (clr_start) clr_cnt <= CCW'(CLRCYCLES);
            else if (clr_act)   clr_cnt <= clr_cnt - CCW'(1);

            if (wipe) begin
                {tie, sae, rie, mse, mai} <= '0;
                rxenab <= '0;
                txenab <= '0;
                prful  <= '0;
                tline  <= '0;
            end else begin
                if (wr_csr & bus_be[0]) begin
                    rie <= bus_wdata[CSR_RIE];
                    mse <= bus_wdata[CSR_MSE];
                    mai <= bus_wdata[CSR_MAI];
                end
                if (wr_csr & bus_be[1]) begin
                    tie <= bus_wdata[CSR_TIE];
                    sae <= bus_wdata[CSR_SAE];
                end
                if (wr_lpr) rxenab[bus_wdata[LW-1:0]] <= bus_wdata[LPR_RXON];
                if (wr_tcr) begin
                    for (int i = 0; i < NLINES; i++)
                        if (i < 8 ? bus_be[0] : bus_be[1]) txenab[i] <= bus_wdata[i];
                end
                if (!trdy) tline <= tline + LW'(1);
                prful <= (prful & ~ack_mask) | set_mask;
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            pr_state <= PR_IDLE;
            pr_valid <= 1'b0;
            rr_ptr   <= '0;
            lb_pend  <= 1'b0;
        end else if (wipe) begin
            pr_state <= PR_IDLE;
            pr_valid <= 1'b0;
            rr_ptr   <= '0;
            lb_pend  <= 1'b0;
        end else begin
            if (lb_push) lb_pend <= 1'b0;
            case (pr_state)
                PR_IDLE: begin
                    if (pr_load) begin
                        pr_state <= PR_BUSY;
                        pr_valid <= 1'b1;
                    end
                end
                PR_BUSY: begin
                    if (pr_ack) begin
                        pr_state <= PR_IDLE;
                        pr_valid <= 1'b0;
                        rr_ptr   <= pr_line + LW'(1);
                        if (mai & rxenab[pr_line]) lb_pend <= 1'b1;
                    end
                end
                default: pr_state <= PR_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (wr_tdr) prbuf[tline] <= bus_wdata[7:0];
        if (pr_load) begin
            pr_line <= pick_line;
            pr_char <= prbuf[pick_line];
        end
        if (pr_done) begin
            lb_line <= pr_line;
            lb_char <= pr_char;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            bus_rdata <= '0;
        end else if (init) begin
            bus_rdata <= '0;
        end else if (bus_rd) begin
            case (bus_addr)
                ADDR_CSR:  bus_rdata <= csr_val;
                ADDR_RBUF: bus_rdata <= rbuf_val;
                ADDR_TCR:  bus_rdata <= 16'(txenab);
                default:   bus_rdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dzmux.sv
// Directed bench for dzmux: 8 lines, 16-entry silo, alarm at 8 entries.
module tb_dzmux;

    localparam int LW = 3;
    localparam logic [1:0] A_CSR = 2'd0, A_RBUF = 2'd1, A_TCR = 2'd2, A_TDR = 2'd3;

    logic          CLOCK = 1'b0;
    logic          RESET = 1'b0;
    logic          init = 1'b0;
    logic          bus_wr = 1'b0, bus_rd = 1'b0;
    logic [1:0]    bus_addr = '0, bus_be = '0;
    logic [15:0]   bus_wdata = '0;
    logic [15:0]   bus_rdata;
    logic          kb_valid = 1'b0;
    logic [LW-1:0] kb_line = '0;
    logic [7:0]    kb_char = '0;
    logic          kb_ready;
    logic          pr_valid;
    logic [LW-1:0] pr_line;
    logic [7:0]    pr_char;
    logic          pr_ack = 1'b0;
    logic          rx_irq, tx_irq;

    int          passed = 0;
    int          total = 0;
    int          fails = 0;
    logic [15:0] rd;

    dzmux #(.NLINES(8), .SILODEPTH(16), .ALARMLVL(8), .CLRCYCLES(1500)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .init(init),
        .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .kb_valid(kb_valid), .kb_line(kb_line), .kb_char(kb_char), .kb_ready(kb_ready),
        .pr_valid(pr_valid), .pr_line(pr_line), .pr_char(pr_char), .pr_ack(pr_ack),
        .rx_irq(rx_irq), .tx_irq(tx_irq)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [1:0] be, input logic [15:0] d);
        bus_wr = 1'b1; bus_addr = a; bus_be = be; bus_wdata = d;
        tick();
        bus_wr = 1'b0; bus_be = 2'b00;
    endtask

    task automatic rdreg(input logic [1:0] a, output logic [15:0] d);
        bus_rd = 1'b1; bus_addr = a;
        tick();
        bus_rd = 1'b0;
        d = bus_rdata;
    endtask

    task automatic kb(input int ln, input logic [7:0] c);
        kb_valid = 1'b1; kb_line = LW'(ln); kb_char = c;
        tick();
        kb_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge CLOCK);
        #1;
        chk("rst_rdata", bus_rdata, 16'h0000);
        chk("rst_pr_valid", 16'(pr_valid), 16'h0);
        chk("rst_kb_ready", 16'(kb_ready), 16'h0);
        chk("rst_irqs", 16'({rx_irq, tx_irq}), 16'h0);
        RESET = 1'b1;
        rdreg(A_CSR, rd);  chk("rst_csr", rd, 16'h0000);
        rdreg(A_RBUF, rd); chk("rst_rbuf", rd, 16'h0000);
        rdreg(A_TCR, rd);  chk("rst_tcr", rd, 16'h0000);

        // Basic receive on line 3
        wr(A_CSR, 2'b01, 16'h0020);
        wr(A_RBUF, 2'b01, 16'h1003);
        chk("kb_ready_mse", 16'(kb_ready), 16'h1);
        kb(3, 8'h41);
        rdreg(A_CSR, rd);  chk("csr_rdone", rd & 16'h00FF, 16'h00A0);
        rdreg(A_RBUF, rd); chk("rbuf_A", rd, 16'h8341);
        rdreg(A_RBUF, rd); chk("rbuf_empty", rd, 16'h0000);
        kb(5, 8'h42);
        rdreg(A_RBUF, rd); chk("rbuf_drop_disabled", rd, 16'h0000);

        // Receive interrupt on RDONE
        wr(A_CSR, 2'b01, 16'h0060);
        chk("rx_irq_empty", 16'(rx_irq), 16'h0);
        kb(3, 8'h42);
        chk("rx_irq_rdone", 16'(rx_irq), 16'h1);
        rdreg(A_RBUF, rd); chk("rbuf_B", rd, 16'h8342);
        chk("rx_irq_drained", 16'(rx_irq), 16'h0);

        // Silo alarm and overrun
        wr(A_CSR, 2'b10, 16'h1000);
        for (int i = 0; i < 7; i++) kb(3, 8'(32'h30 + i));
        chk("rx_irq_below_alarm", 16'(rx_irq), 16'h0);
        rdreg(A_CSR, rd); chk("sa_7", (rd >> 13) & 16'h1, 16'h0);
        kb(3, 8'h37);
        chk("rx_irq_alarm", 16'(rx_irq), 16'h1);
        rdreg(A_CSR, rd); chk("sa_8", (rd >> 13) & 16'h1, 16'h1);
        for (int i = 8; i < 17; i++) kb(3, 8'(32'h30 + i));
        for (int i = 0; i < 16; i++) begin
            rdreg(A_RBUF, rd);
            chk($sformatf("ovr_rd%0d", i), rd, (i == 15) ? 16'hC33F : 16'(32'h8330 + i));
        end
        rdreg(A_RBUF, rd); chk("ovr_rd_empty", rd, 16'h0000);

        // Push and pop together while full
        for (int i = 0; i < 16; i++) kb(3, 8'(32'h60 + i));
        kb_valid = 1'b1; kb_line = 3'd3; kb_char = 8'h70;
        bus_rd = 1'b1; bus_addr = A_RBUF;
        tick();
        kb_valid = 1'b0; bus_rd = 1'b0;
        chk("full_pushpop", bus_rdata, 16'h8360);
        for (int i = 1; i < 17; i++) begin
            rdreg(A_RBUF, rd);
            chk($sformatf("full_rd%0d", i), rd, 16'(32'h8360 + i));
        end
        rdreg(A_RBUF, rd); chk("full_rd_empty", rd, 16'h0000);
        wr(A_CSR, 2'b11, 16'h0020);

        // Transmit scanner and printer handshake
        wr(A_TCR, 2'b01, 16'h0001);
        repeat (8) tick();
        rdreg(A_CSR, rd); chk("scan_line0", rd & 16'h8F00, 16'h8000);
        wr(A_TCR, 2'b01, 16'h0005);
        rdreg(A_TCR, rd); chk("tcr_05", rd, 16'h0005);
        wr(A_CSR, 2'b11, 16'h4020);
        chk("tx_irq_trdy", 16'(tx_irq), 16'h1);
        wr(A_TDR, 2'b01, 16'h0055);
        repeat (3) tick();
        chk("pr_valid_0", 16'(pr_valid), 16'h1);
        chk("pr_line_0", 16'(pr_line), 16'h0);
        chk("pr_char_55", 16'(pr_char), 16'h0055);
        rdreg(A_CSR, rd); chk("scan_line2", rd & 16'h8F00, 16'h8200);
        chk("tx_irq_line2", 16'(tx_irq), 16'h1);
        repeat (2) tick();
        chk("pr_hold", {7'(0), pr_valid, pr_char}, 16'h0155);
        pr_ack = 1'b1; tick(); pr_ack = 1'b0;
        chk("pr_acked", 16'(pr_valid), 16'h0);
        repeat (3) tick();
        chk("pr_no_repeat", 16'(pr_valid), 16'h0);

        // Maintenance loopback on line 2
        wr(A_RBUF, 2'b01, 16'h1002);
        wr(A_TCR, 2'b01, 16'h0004);
        wr(A_CSR, 2'b01, 16'h0028);
        wr(A_TDR, 2'b01, 16'h007E);
        repeat (2) tick();
        chk("lb_pr_valid", 16'(pr_valid), 16'h1);
        chk("lb_pr_line", 16'(pr_line), 16'h2);
        chk("lb_pr_char", 16'(pr_char), 16'h007E);
        pr_ack = 1'b1; tick(); pr_ack = 1'b0;
        tick();
        rdreg(A_RBUF, rd); chk("lb_rbuf", rd, 16'h827E);
        rdreg(A_RBUF, rd); chk("lb_rbuf_empty", rd, 16'h0000);

        // Asynchronous reset during a pending print
        repeat (8) tick();
        wr(A_TDR, 2'b01, 16'h0011);
        repeat (2) tick();
        chk("pend_pr_valid", 16'(pr_valid), 16'h1);
        #2 RESET = 1'b0;
        #1;
        chk("async_pr_valid", 16'(pr_valid), 16'h0);
        chk("async_rdata", bus_rdata, 16'h0000);
        chk("async_kb_ready", 16'(kb_ready), 16'h0);
        tick();
        RESET = 1'b1;

        // CLR sequence
        wr(A_CSR, 2'b01, 16'h0020);
        wr(A_RBUF, 2'b01, 16'h1001);
        wr(A_TCR, 2'b01, 16'h00FF);
        kb(0, 8'h43);
        wr(A_CSR, 2'b01, 16'h0010);
        chk("clr_kb_ready", 16'(kb_ready), 16'h0);
        wr(A_TCR, 2'b01, 16'h00FF);
        repeat (1498) tick();
        rdreg(A_CSR, rd); chk("clr_last", rd, 16'h0010);
        rdreg(A_CSR, rd); chk("clr_done", rd, 16'h0000);
        rdreg(A_TCR, rd); chk("clr_tcr", rd, 16'h0000);
        rdreg(A_RBUF, rd); chk("clr_rbuf", rd, 16'h0000);
        wr(A_CSR, 2'b01, 16'h0020);
        kb(0, 8'h44);
        rdreg(A_RBUF, rd); chk("clr_rxenab", rd, 16'h0000);

        // Synchronous init
        wr(A_RBUF, 2'b01, 16'h1000);
        kb(0, 8'h45);
        rdreg(A_CSR, rd);
        init = 1'b1; tick(); init = 1'b0;
        chk("init_rdata", bus_rdata, 16'h0000);
        chk("init_kb_ready", 16'(kb_ready), 16'h0);
        rdreg(A_RBUF, rd); chk("init_rbuf", rd, 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dzmux.md
DZMUX -- requirements
Module: dzmux

Interface
REQ-001 Parameter NLINES, default 8: number of serial lines; power of 2, 4..16; LW = log2(NLINES).
REQ-002 Parameter SILODEPTH, default 64: receive silo entries; power of 2, 16..256.
REQ-003 Parameter ALARMLVL, default 16: silo fill count that raises the silo alarm; 1..SILODEPTH.
REQ-004 Parameter CLRCYCLES, default 1500: duration of the CLR sequence in clocks.
REQ-005 CLOCK  in  1  single clock; all state changes on rising edge.
REQ-006 RESET  in  1  asynchronous, active-low; clears all state.
REQ-007 init  in  1  synchronous bus INIT; clears the same state as RESET.
REQ-008 bus_wr, bus_rd  in  1  one-cycle register write/read strobes; never both high.
REQ-009 bus_addr  in  2  register select: 0 CSR, 1 RBUF(rd)/LPR(wr), 2 TCR, 3 TDR.
REQ-010 bus_be  in  2  byte enables for writes; [0] low byte, [1] high byte.
REQ-011 bus_wdata  in  16  write data.  bus_rdata  out  16  read data, registered.
REQ-012 kb_valid  in  1 / kb_line  in  LW / kb_char  in  8 / kb_ready  out  1  host-to-silo keyboard handshake.
REQ-013 pr_valid  out  1 / pr_line  out  LW / pr_char  out  8 / pr_ack  in  1  silo-to-host printer handshake.
REQ-014 rx_irq, tx_irq  out  1  interrupt request levels.

Function
REQ-015 CSR: [15] TRDY, [14] TIE, [13] SA, [12] SAE, [11:8] TLINE (upper bits 0 when LW<4), [7] RDONE, [6] RIE, [5] MSE, [4] CLR, [3] MAI, others 0.
REQ-016 RBUF read: [15] valid, [14] overrun, [11:8] line, [7:0] char; a read with valid=1 pops the silo in the same cycle.
REQ-017 bus_rdata valid the cycle after bus_rd; unpopulated registers read 0; TCR reads [NLINES-1:0] txenab.
REQ-018 LPR write (be[0]): rxenab[wdata[LW-1:0]] <= wdata[12]; TCR write: txenab per enabled byte; TDR write (be[0]): prbuf[TLINE] <= wdata[7:0], prful[TLINE] <= 1.
REQ-019 Writing CSR[4]=1 starts CLR: CLR reads 1 for exactly CLRCYCLES clocks, holding all non-config state at reset values; bus writes during CLR are ignored.
REQ-020 Silo: circular FIFO of {line, char}; count 0..SILODEPTH; RDONE = count!=0; SA = count>=ALARMLVL.
REQ-021 kb_ready = MSE & ~CLR; kb_valid&kb_ready with rxenab[kb_line] pushes; disabled-line chars are dropped silently.
REQ-022 Push when full: entry discarded, overrun flag set on the newest stored entry; flag is returned on its RBUF read.
REQ-023 Simultaneous push and pop: both occur, count unchanged; push on full with simultaneous pop succeeds.
REQ-024 Scanner: when TRDY=0, TLINE advances by 1 (mod NLINES) per clock; TRDY = txenab[TLINE] & ~prful[TLINE].
REQ-025 Printer arbiter: round-robin over lines with prful; pr_valid holds pr_line/pr_char stable until pr_ack; on ack prful[line] clears and search restarts at line+1.
REQ-026 Loopback: with MAI=1 the acked char is also pushed into the silo if rxenab[line]; kb push has priority, loopback retried next cycle.
REQ-027 rx_irq = RIE & (SAE ? SA : RDONE); tx_irq = TIE & TRDY; both combinational from registers.

Reset
REQ-028 RESET low or init high: all CSR bits, rxenab, txenab, prful, silo pointers/count, TLINE, CLR counter = 0; bus_rdata = 0; pr_valid = 0; kb_ready = 0.
REQ-029 Reset mid-handshake abandons any pending pr_valid without ack; silo contents become unreadable.

Structure
REQ-030 Shared package dzmux_pkg: register address constants, CSR/RBUF bit positions, silo entry struct.
REQ-031 One sub-module dzmux_silo (parametrised FIFO with count, full, overrun tagging).

Verification
REQ-032 MSE=1, rxenab[3]=1, kb 'A' line 3 -> RBUF read 0x8341, second read 0x0000.
REQ-033 SILODEPTH=16, push 17 chars -> 16 stored, 16th read has bit 14 set, SA=1 when ALARMLVL reached.
REQ-034 txenab=0x05, TDR write 0x55 -> prful[TLINE], TLINE scans to line 2, pr_valid line 0 char 0x55, ack clears it.
REQ-035 MAI=1, rxenab[2]=1, print 0x7E on line 2, pr_ack -> RBUF 0x827E.
REQ-036 CSR write 0x0010 -> CLR=1 for 1500 clocks, then 0; all enables cleared.
REQ-037 RESET asserted while pr_valid=1 -> pr_valid=0 immediately, no ack required.
